// File: rtl/dst_mac_extractor_pkg.sv
// Shared stream type for the header tap and dest_calculator.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package dst_mac_extractor_pkg;

    typedef struct packed {
        logic [15:0] tdata;
        logic        tvalid;
        logic        tlast;
        logic        tuser;
    } packet_source_t;

endpackage

// File: rtl/dst_mac_extractor.sv
// Passive tap: captures the 3 destination-MAC beats of each ingress frame and
// replays them as exactly 3 consecutive valid words (runts padded with PAD_WORD).
// Latency: 3rd header beat on cycle N -> word0 at N+1, word2 at N+3. Never stalls ingress;
// a header completing while the previous one is still mid-emission is dropped and counted.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   ingress_t*            observed ingress stream (beat = tvalid & tready)
//   dst_mac_pkt           header words for dest_calculator (tdata/tvalid only)
//   runt_cnt, drop_cnt    saturating statistics
//   busy                  capture mid-frame or emission in progress
module dst_mac_extractor
    import dst_mac_extractor_pkg::*;
#(
    parameter logic [15:0] PAD_WORD = 16'hFFFF,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      ingress_tdata,
    input  logic             ingress_tvalid,
    input  logic             ingress_tready,
    input  logic             ingress_tlast,
    output packet_source_t   dst_mac_pkt,
    output logic [CNT_W-1:0] runt_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic             busy
);

    typedef enum logic [1:0] {
        HDR0 = 2'd0,
        HDR1 = 2'd1,
        HDR2 = 2'd2,
        BODY = 2'd3
    } cap_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    cap_state_t  state;
    logic [15:0] cap0;
    logic [15:0] cap1;

    // Emitter: word0 goes straight to the output register on load, so only
    // words 1 and 2 need holding. emit_idx is the index currently on the output.
    logic        emit_active;
    logic [1:0]  emit_idx;
    logic [15:0] emit_buf1;
    logic [15:0] emit_buf2;
    logic [15:0] out_tdata;
    logic        out_tvalid;

    logic        beat;
    logic        cmpl;
    logic        runt;
    logic        can_load;
    logic [15:0] hw0;
    logic [15:0] hw1;
    logic [15:0] hw2;

    assign beat = ingress_tvalid & ingress_tready;

    always_comb begin
        cmpl = 1'b0;
        runt = 1'b0;
        hw0  = PAD_WORD;
        hw1  = PAD_WORD;
        hw2  = PAD_WORD;
        if (beat) begin
            case (state)
                HDR0, HDR1: begin
                    cmpl = ingress_tlast;
                    runt = ingress_tlast;
                end
                HDR2: begin
                    // Third word is taken live so the header completes on its own beat.
                    cmpl = 1'b1;
                    hw0  = cap0;
                    hw1  = cap1;
                    hw2  = ingress_tdata;
                end
                default: ;
            endcase
        end
    end

    // Loading is allowed while word2 is on the output: the new word0 follows it
    // with no gap, keeping the downstream modulo-3 count aligned.
    assign can_load = !emit_active || (emit_idx == 2'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HDR0;
            cap0        <= '0;
            cap1        <= '0;
            emit_active <= 1'b0;
            emit_idx    <= 2'd0;
            emit_buf1   <= '0;
            emit_buf2   <= '0;
            out_tdata   <= '0;
            out_tvalid  <= 1'b0;
            runt_cnt    <= '0;
            drop_cnt    <= '0;
        end else begin
            // Capture FSM
            if (beat) begin
                case (state)
                    HDR0: begin
                        cap0 <= ingress_tdata;
                        if (!ingress_tlast) state <= HDR1;
                    end
                    HDR1: begin
                        cap1  <= ingress_tdata;
                        state <= ingress_tlast ? HDR0 : HDR2;
                    end
                    HDR2: state <= ingress_tlast ? HDR0 : BODY;
                    BODY: if (ingress_tlast) state <= HDR0;
                    default: state <= HDR0;
                endcase
            end

            // Emitter
            if (cmpl && can_load) begin
                out_tdata   <= hw0;
                out_tvalid  <= 1'b1;
                emit_buf1   <= hw1;
                emit_buf2   <= hw2;
                emit_idx    <= 2'd0;
                emit_active <= 1'b1;
            end else if (emit_active) begin
                case (emit_idx)
                    2'd0: begin
                        out_tdata <= emit_buf1;
                        emit_idx  <= 2'd1;
                    end
                    2'd1: begin
                        out_tdata <= emit_buf2;
                        emit_idx  <= 2'd2;
                    end
                    default: begin
                        // tdata holds the last word emitted
                        out_tvalid  <= 1'b0;
                        emit_active <= 1'b0;
                        emit_idx    <= 2'd0;
                    end
                endcase
            end

            // Statistics (saturating)
            if (runt && (runt_cnt != '1))
                runt_cnt <= runt_cnt + CNT_ONE;
            if (cmpl && !can_load && (drop_cnt != '1))
                drop_cnt <= drop_cnt + CNT_ONE;
        end
    end

    assign busy = (state != HDR0) || emit_active;

    always_comb begin
        dst_mac_pkt        = '0;
        dst_mac_pkt.tdata  = out_tdata;
        dst_mac_pkt.tvalid = out_tvalid;
    end

endmodule

// File: tb/tb_dst_mac_extractor.sv
// Directed self-checking bench for dst_mac_extractor.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Each scenario task drives its vectors and checks the hand-computed results inline.
module tb_dst_mac_extractor;
    import dst_mac_extractor_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic [15:0]    ingress_tdata;
    logic           ingress_tvalid;
    logic           ingress_tready;
    logic           ingress_tlast;
    packet_source_t dst_mac_pkt;
    logic [15:0]    runt_cnt;
    logic [15:0]    drop_cnt;
    logic           busy;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dst_mac_extractor #(.PAD_WORD(16'hFFFF), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .ingress_tdata  (ingress_tdata),
        .ingress_tvalid (ingress_tvalid),
        .ingress_tready (ingress_tready),
        .ingress_tlast  (ingress_tlast),
        .dst_mac_pkt    (dst_mac_pkt),
        .runt_cnt       (runt_cnt),
        .drop_cnt       (drop_cnt),
        .busy           (busy)
    );

    // Present one accepted beat for one clock, then settle past the edge.
    task automatic beat(input logic [15:0] d, input logic last);
        ingress_tdata  = d;
        ingress_tvalid = 1'b1;
        ingress_tready = 1'b1;
        ingress_tlast  = last;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ingress_tvalid = 1'b0;
        ingress_tlast  = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        ingress_tdata  = 16'h0;
        ingress_tvalid = 1'b0;
        ingress_tready = 1'b1;
        ingress_tlast  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (dst_mac_pkt !== '0 || runt_cnt !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: got pkt=%h runt=%0d drop=%0d busy=%b, want pkt=0 runt=0 drop=0 busy=0",
                     dst_mac_pkt, runt_cnt, drop_cnt, busy);
        end
    endtask

    task automatic test_long_frame();
        logic [15:0] exp [3];
        exp = '{16'h0123, 16'h4567, 16'h89AB};
        beat(16'h0123, 1'b0);
        beat(16'h4567, 1'b0);
        beat(16'h89AB, 1'b0);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== exp[i] || busy !== 1'b1) begin
                miscompares++;
                $display("FAIL long_word%0d: got vld=%b dat=%h busy=%b, want vld=1 dat=%h busy=1",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata, busy, exp[i]);
            end
            if (i == 0) beat(16'h0001, 1'b0);
            else if (i == 1) beat(16'h0002, 1'b1);
            else idle();
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || dst_mac_pkt.tdata !== 16'h89AB ||
            runt_cnt !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL long_after: got vld=%b dat=%h runt=%0d drop=%0d busy=%b, want vld=0 dat=89ab runt=0 drop=0 busy=0",
                     dst_mac_pkt.tvalid, dst_mac_pkt.tdata, runt_cnt, drop_cnt, busy);
        end
    endtask

    task automatic test_runt2();
        beat(16'h1111, 1'b0);
        beat(16'h2222, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL runt2_word%0d: got vld=%b dat=%h, want vld=1 dat=ffff",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata);
            end
            idle();
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || runt_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
            miscompares++;
            $display("FAIL runt2_after: got vld=%b runt=%0d drop=%0d, want vld=0 runt=1 drop=0",
                     dst_mac_pkt.tvalid, runt_cnt, drop_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] in  [6];
        logic [15:0] exp [6];
        in  = '{16'hA001, 16'hA002, 16'hA003, 16'hB001, 16'hB002, 16'hB003};
        exp = '{16'hA001, 16'hA002, 16'hA003, 16'hB001, 16'hB002, 16'hB003};
        for (int i = 0; i < 3; i++) beat(in[i], i == 2);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== exp[i]) begin
                miscompares++;
                $display("FAIL b2b_word%0d: got vld=%b dat=%h, want vld=1 dat=%h",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata, exp[i]);
            end
            if (i < 3) beat(in[i+3], i == 2);
            else idle();
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || drop_cnt !== 16'd0 || runt_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL b2b_after: got vld=%b drop=%0d runt=%0d, want vld=0 drop=0 runt=1",
                     dst_mac_pkt.tvalid, drop_cnt, runt_cnt);
        end
    endtask

    task automatic test_runt_drop();
        beat(16'hAAAA, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== 16'hFFFF) begin
                miscompares++;
                $display("FAIL runt1_word%0d: got vld=%b dat=%h, want vld=1 dat=ffff",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata);
            end
            if (i == 0) beat(16'hBBBB, 1'b1);
            else idle();
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || runt_cnt !== 16'd3 || drop_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL runt1_after: got vld=%b runt=%0d drop=%0d, want vld=0 runt=3 drop=1",
                     dst_mac_pkt.tvalid, runt_cnt, drop_cnt);
        end
    endtask

    task automatic test_stall();
        logic [15:0] exp [3];
        exp = '{16'hC0C0, 16'hC1C1, 16'hC2C2};
        beat(16'hC0C0, 1'b0);
        ingress_tdata  = 16'hDEAD;
        ingress_tvalid = 1'b1;
        ingress_tready = 1'b0;
        ingress_tlast  = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || busy !== 1'b1 || runt_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL stall_hold: got vld=%b busy=%b runt=%0d, want vld=0 busy=1 runt=3",
                     dst_mac_pkt.tvalid, busy, runt_cnt);
        end
        beat(16'hC1C1, 1'b0);
        beat(16'hC2C2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== exp[i]) begin
                miscompares++;
                $display("FAIL stall_word%0d: got vld=%b dat=%h, want vld=1 dat=%h",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata, exp[i]);
            end
            idle();
        end
    endtask

    task automatic test_reset_mid_emit();
        logic [15:0] exp [3];
        exp = '{16'hE000, 16'hE111, 16'hE222};
        beat(16'hD000, 1'b0);
        beat(16'hD111, 1'b0);
        beat(16'hD222, 1'b1);
        idle();
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== 16'hD111) begin
            miscompares++;
            $display("FAIL rst_pre: got vld=%b dat=%h, want vld=1 dat=d111",
                     dst_mac_pkt.tvalid, dst_mac_pkt.tdata);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || dst_mac_pkt.tdata !== 16'h0 ||
            runt_cnt !== 16'd0 || drop_cnt !== 16'd0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid: got vld=%b dat=%h runt=%0d drop=%0d busy=%b, want vld=0 dat=0 runt=0 drop=0 busy=0",
                     dst_mac_pkt.tvalid, dst_mac_pkt.tdata, runt_cnt, drop_cnt, busy);
        end
        for (int i = 0; i < 3; i++) beat(exp[i], i == 2);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (dst_mac_pkt.tvalid !== 1'b1 || dst_mac_pkt.tdata !== exp[i]) begin
                miscompares++;
                $display("FAIL rst_word%0d: got vld=%b dat=%h, want vld=1 dat=%h",
                         i, dst_mac_pkt.tvalid, dst_mac_pkt.tdata, exp[i]);
            end
            idle();
        end
        vectors++;
        if (dst_mac_pkt.tvalid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_after: got vld=%b busy=%b, want vld=0 busy=0",
                     dst_mac_pkt.tvalid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_long_frame();
        test_runt2();
        test_back_to_back();
        test_runt_drop();
        test_stall();
        test_reset_mid_emit();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
